// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter that shares one UDP transmit path between a frame-payload
// channel (ch0) and a command-reply channel (ch1), with watchdog and inter-packet gap.
module udp_tx_arbiter #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_BYTES      = 1472
) (
  input  logic        i_gmii_tx_clk,
  input  logic        i_sys_rst,
  input  logic        i_ch0_req,
  input  logic        i_ch1_req,
  input  logic [15:0] i_ch0_byte_num,
  input  logic [15:0] i_ch1_byte_num,
  input  logic [47:0] i_ch0_des_mac,
  input  logic [47:0] i_ch1_des_mac,
  input  logic [31:0] i_ch0_des_ip,
  input  logic [31:0] i_ch1_des_ip,
  input  logic [31:0] i_ch0_data,
  input  logic [31:0] i_ch1_data,
  output logic        o_ch0_grant,
  output logic        o_ch1_grant,
  output logic        o_ch0_data_req,
  output logic        o_ch1_data_req,
  output logic        o_ch0_done,
  output logic        o_ch1_done,
  output logic        o_ch0_err,
  output logic        o_ch1_err,
  output logic        o_tx_start_en,
  output logic [15:0] o_tx_byte_num,
  output logic [47:0] o_des_mac,
  output logic [31:0] o_des_ip,
  output logic [31:0] o_tx_data,
  input  logic        i_fifo_data_req,
  input  logic        i_tx_done,
  input  logic        i_gmii_tx_busy,
  output logic        o_timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  localparam logic [23:0] WD_LAST  = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_BYTES);

  state_t      state, state_next;
  logic        last_grant, last_grant_next;
  logic [23:0] wd_cnt, wd_cnt_next;
  logic [15:0] gap_cnt, gap_cnt_next;
  logic        grant0_next, grant1_next;
  logic        start_next, timeout_next;
  logic        done0_next, done1_next, err0_next, err1_next;
  logic        latch_en, win_ch;
  logic        len_bad, in_wait;

  assign len_bad = (o_tx_byte_num == 16'd0) || (o_tx_byte_num > MAX_LEN);
  assign in_wait = (state == WAIT_DONE);

  // Wrapper-facing data path is live only while a packet is actually in flight.
  assign o_ch0_data_req = in_wait & i_fifo_data_req & o_ch0_grant;
  assign o_ch1_data_req = in_wait & i_fifo_data_req & o_ch1_grant;
  assign o_tx_data      = !in_wait    ? 32'd0      :
                          o_ch1_grant ? i_ch1_data : i_ch0_data;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
    state_next      = state;
    last_grant_next = last_grant;
    wd_cnt_next     = wd_cnt;
    gap_cnt_next    = gap_cnt;
    grant0_next     = o_ch0_grant;
    grant1_next     = o_ch1_grant;
    start_next      = 1'b0;
    timeout_next    = 1'b0;
    done0_next      = 1'b0;
    done1_next      = 1'b0;
    err0_next       = 1'b0;
    err1_next       = 1'b0;
    latch_en        = 1'b0;
    win_ch          = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_ch0_req || i_ch1_req) begin
          // On a tie the channel that did not win last time goes first.
          win_ch          = (i_ch0_req && i_ch1_req) ? ~last_grant : i_ch1_req;
          latch_en        = 1'b1;
          last_grant_next = win_ch;
          grant0_next     = ~win_ch;
          grant1_next     = win_ch;
          state_next      = START;
        end
      end
      START: begin
        if (len_bad) begin
          done0_next   = o_ch0_grant;
          done1_next   = o_ch1_grant;
          err0_next    = o_ch0_grant;
          err1_next    = o_ch1_grant;
          grant0_next  = 1'b0;
          grant1_next  = 1'b0;
          gap_cnt_next = 16'd0;
          state_next   = GAP;
        end else if (i_gmii_tx_busy) begin
          start_next  = 1'b1;
          wd_cnt_next = 24'd0;
          state_next  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_cnt_next = wd_cnt + 24'd1;
        if (i_tx_done || wd_cnt == WD_LAST) begin
          // A done arriving on the expiry cycle still counts as a clean finish.
          done0_next   = o_ch0_grant;
          done1_next   = o_ch1_grant;
          err0_next    = o_ch0_grant & ~i_tx_done;
          err1_next    = o_ch1_grant & ~i_tx_done;
          timeout_next = ~i_tx_done;
          grant0_next  = 1'b0;
          grant1_next  = 1'b0;
          gap_cnt_next = 16'd0;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_gmii_tx_clk) begin
    if (i_sys_rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      wd_cnt        <= 24'd0;
      gap_cnt       <= 16'd0;
      o_ch0_grant   <= 1'b0;
      o_ch1_grant   <= 1'b0;
      o_ch0_done    <= 1'b0;
      o_ch1_done    <= 1'b0;
      o_ch0_err     <= 1'b0;
      o_ch1_err     <= 1'b0;
      o_tx_start_en <= 1'b0;
      o_timeout_err <= 1'b0;
      o_tx_byte_num <= 16'd0;
      o_des_mac     <= 48'd0;
      o_des_ip      <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
      state         <= state_next;
      last_grant    <= last_grant_next;
      wd_cnt        <= wd_cnt_next;
      gap_cnt       <= gap_cnt_next;
      o_ch0_grant   <= grant0_next;
      o_ch1_grant   <= grant1_next;
      o_ch0_done    <= done0_next;
      o_ch1_done    <= done1_next;
      o_ch0_err     <= err0_next;
      o_ch1_err     <= err1_next;
      o_tx_start_en <= start_next;
      o_timeout_err <= timeout_next;
      if (latch_en) begin
        o_tx_byte_num <= win_ch ? i_ch1_byte_num : i_ch0_byte_num;
        o_des_mac     <= win_ch ? i_ch1_des_mac  : i_ch0_des_mac;
        o_des_ip      <= win_ch ? i_ch1_des_ip   : i_ch0_des_ip;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: arbitration vector table, round-robin,
// reject, busy stall, watchdog and reset sequences, with a done-pulse scoreboard.
module tb_udp_tx_arbiter;

  localparam int IFG  = 12;
  localparam int TMO  = 100;
  localparam int MAXB = 1472;

  localparam logic [47:0] MAC0  = 48'h0200_0000_00A0;
  localparam logic [47:0] MAC1  = 48'h0200_0000_00B1;
  localparam logic [31:0] IP0   = 32'hC0A8_0001;
  localparam logic [31:0] IP1   = 32'hC0A8_0002;
  localparam logic [31:0] DATA0 = 32'hD0D0_0000;
  localparam logic [31:0] DATA1 = 32'hD1D1_1111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_sys_rst;
  logic        i_ch0_req, i_ch1_req;
  logic [15:0] i_ch0_byte_num, i_ch1_byte_num;
  logic        i_fifo_data_req, i_tx_done, i_gmii_tx_busy;
  logic        o_ch0_grant, o_ch1_grant, o_ch0_data_req, o_ch1_data_req;
  logic        o_ch0_done, o_ch1_done, o_ch0_err, o_ch1_err;
  logic        o_tx_start_en, o_timeout_err;
  logic [15:0] o_tx_byte_num;
  logic [47:0] o_des_mac;
  logic [31:0] o_des_ip, o_tx_data;

  udp_tx_arbiter #(
    .IFG_CYCLES    (IFG),
    .TIMEOUT_CYCLES(TMO),
    .MAX_BYTES     (MAXB)
  ) dut (
    .i_gmii_tx_clk (clk),
    .i_sys_rst     (i_sys_rst),
    .i_ch0_req     (i_ch0_req),
    .i_ch1_req     (i_ch1_req),
    .i_ch0_byte_num(i_ch0_byte_num),
    .i_ch1_byte_num(i_ch1_byte_num),
    .i_ch0_des_mac (MAC0),
    .i_ch1_des_mac (MAC1),
    .i_ch0_des_ip  (IP0),
    .i_ch1_des_ip  (IP1),
    .i_ch0_data    (DATA0),
    .i_ch1_data    (DATA1),
    .o_ch0_grant   (o_ch0_grant),
    .o_ch1_grant   (o_ch1_grant),
    .o_ch0_data_req(o_ch0_data_req),
    .o_ch1_data_req(o_ch1_data_req),
    .o_ch0_done    (o_ch0_done),
    .o_ch1_done    (o_ch1_done),
    .o_ch0_err     (o_ch0_err),
    .o_ch1_err     (o_ch1_err),
    .o_tx_start_en (o_tx_start_en),
    .o_tx_byte_num (o_tx_byte_num),
    .o_des_mac     (o_des_mac),
    .o_des_ip      (o_des_ip),
    .o_tx_data     (o_tx_data),
    .i_fifo_data_req(i_fifo_data_req),
    .i_tx_done     (i_tx_done),
    .i_gmii_tx_busy(i_gmii_tx_busy),
    .o_timeout_err (o_timeout_err)
  );

  typedef struct {
    logic        r0, r1;
    logic [15:0] len0, len1;
    logic        exp_g0, exp_g1, exp_rej;
    int          wait_cyc;
  } vec_t;

  typedef struct {
    logic ch;
    logic err;
    logic to;
  } exp_done_t;

  exp_done_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(o_ch0_grant | o_ch1_grant) && n < budget);
    check("grant_wait", o_ch0_grant | o_ch1_grant, 1);
  endtask

  // In a WAIT_DONE cycle: verify routing, then finish the packet with a tx_done pulse.
  task automatic complete_pkt(input logic ch, input string tag);
    i_fifo_data_req = 1'b1;
    #1;
    check({tag, " data_req"}, {o_ch1_data_req, o_ch0_data_req}, ch ? 2'b10 : 2'b01);
    check({tag, " tx_data"}, o_tx_data, ch ? DATA1 : DATA0);
    sb.push_back('{ch: ch, err: 1'b0, to: 1'b0});
    i_tx_done = 1'b1;
    step();
    i_tx_done       = 1'b0;
    i_fifo_data_req = 1'b0;
    check({tag, " grant_clr"}, {o_ch1_grant, o_ch0_grant}, 2'b00);
  endtask

  // Every-cycle invariants and the done-pulse scoreboard.
  always @(posedge clk) begin
    #1;
    if (!i_sys_rst) begin
      check("grant_onehot", o_ch0_grant & o_ch1_grant, 0);
      check("data_req_leak", {o_ch1_data_req & ~o_ch1_grant, o_ch0_data_req & ~o_ch0_grant}, 0);
      check("err_without_done",
            (o_ch0_err | o_ch1_err | o_timeout_err) & ~(o_ch0_done | o_ch1_done), 0);
      if (o_ch0_done | o_ch1_done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", {o_ch1_done, o_ch0_done}, 2'b00);
        end else begin
          exp_done_t e;
          e = sb.pop_front();
          check("done_ch", {o_ch1_done, o_ch0_done}, e.ch ? 2'b10 : 2'b01);
          check("done_err", {o_ch1_err, o_ch0_err}, e.err ? (e.ch ? 2'b10 : 2'b01) : 2'b00);
          check("done_timeout", o_timeout_err, e.to);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[10];

  initial begin
    int   n;
    logic seen;
    logic owner;

    // Expected winners follow last_grant, which starts at 1 after reset.
    vecs[0] = '{1'b1, 1'b0, 16'd1024, 16'd0,    1'b1, 1'b0, 1'b0, 50};
    vecs[1] = '{1'b1, 1'b1, 16'd100,  16'd200,  1'b0, 1'b1, 1'b0, 3};
    vecs[2] = '{1'b1, 1'b1, 16'd100,  16'd200,  1'b1, 1'b0, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b1, 16'd0,    16'd0,    1'b0, 1'b1, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b1, 16'd0,    16'd1500, 1'b0, 1'b1, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b0, 16'd1472, 16'd0,    1'b1, 1'b0, 1'b0, 3};
    vecs[6] = '{1'b0, 1'b1, 16'd0,    16'd1,    1'b0, 1'b1, 1'b0, 3};
    vecs[7] = '{1'b1, 1'b0, 16'd1473, 16'd0,    1'b1, 1'b0, 1'b1, 0};
    vecs[8] = '{1'b1, 1'b1, 16'd64,   16'd1473, 1'b0, 1'b1, 1'b1, 0};
    vecs[9] = '{1'b1, 1'b1, 16'd64,   16'd1473, 1'b1, 1'b0, 1'b0, 3};

    i_sys_rst       = 1'b1;
    i_ch0_req       = 1'b0;
    i_ch1_req       = 1'b0;
    i_ch0_byte_num  = 16'd0;
    i_ch1_byte_num  = 16'd0;
    i_fifo_data_req = 1'b0;
    i_tx_done       = 1'b0;
    i_gmii_tx_busy  = 1'b1;
    repeat (3) step();
    check("reset grants", {o_ch1_grant, o_ch0_grant}, 0);
    check("reset pulses", {o_tx_start_en, o_ch0_done, o_ch1_done, o_ch0_err, o_ch1_err, o_timeout_err}, 0);
    check("reset byte_num", o_tx_byte_num, 0);
    check("reset des_mac", o_des_mac, 0);
    check("reset des_ip", o_des_ip, 0);
    i_sys_rst = 1'b0;
    step();

    // Arbitration table: each vector starts in an IDLE cycle and runs to the end of GAP.
    for (int i = 0; i < 10; i++) begin
      vec_t  v;
      logic  ch;
      string tag;
      v   = vecs[i];
      ch  = v.exp_g1;
      tag = $sformatf("vec%0d", i);
      i_ch0_req       = v.r0;
      i_ch1_req       = v.r1;
      i_ch0_byte_num  = v.len0;
      i_ch1_byte_num  = v.len1;
      i_fifo_data_req = 1'b1;
      step();
      check({tag, " grant"}, {o_ch1_grant, o_ch0_grant}, {v.exp_g1, v.exp_g0});
      check({tag, " byte_num"}, o_tx_byte_num, ch ? v.len1 : v.len0);
      check({tag, " des_mac"}, o_des_mac, ch ? MAC1 : MAC0);
      check({tag, " des_ip"}, o_des_ip, ch ? IP1 : IP0);
      check({tag, " data_req_idle"}, {o_ch1_data_req, o_ch0_data_req}, 2'b00);
      check({tag, " start_early"}, o_tx_start_en, 0);
      if (v.exp_rej) begin
        sb.push_back('{ch: ch, err: 1'b1, to: 1'b0});
        step();
        check({tag, " rej grant_clr"}, {o_ch1_grant, o_ch0_grant}, 2'b00);
        check({tag, " rej no_start"}, o_tx_start_en, 0);
        i_ch0_req       = 1'b0;
        i_ch1_req       = 1'b0;
        i_fifo_data_req = 1'b0;
        i_tx_done       = 1'b1;
        step();
        i_tx_done = 1'b0;
        check({tag, " rej gap_start"}, o_tx_start_en, 0);
        repeat (IFG - 1) step();
      end else begin
        i_fifo_data_req = 1'b0;
        step();
        check({tag, " start"}, o_tx_start_en, 1);
        step();
        check({tag, " start_once"}, o_tx_start_en, 0);
        repeat (v.wait_cyc) step();
        complete_pkt(ch, tag);
        i_ch0_req = 1'b0;
        i_ch1_req = 1'b0;
        repeat (IFG) step();
      end
    end

    // Continuous requests from both channels: owners alternate, IFG+1 cycles from done to next grant.
    i_ch0_req      = 1'b1;
    i_ch1_req      = 1'b1;
    i_ch0_byte_num = 16'd300;
    i_ch1_byte_num = 16'd400;
    owner          = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(40, n);
      check("rr grant_latency", n, (k == 0) ? 1 : IFG + 1);
      check("rr owner", {o_ch1_grant, o_ch0_grant}, owner ? 2'b10 : 2'b01);
      step();
      check("rr start", o_tx_start_en, 1);
      step();
      complete_pkt(owner, "rr");
      owner = ~owner;
    end
    i_ch0_req = 1'b0;
    i_ch1_req = 1'b0;
    repeat (IFG) step();

    // Transmitter busy for 30 cycles after grant; requester drops req before done.
    i_ch0_req      = 1'b1;
    i_ch0_byte_num = 16'd500;
    i_gmii_tx_busy = 1'b0;
    step();
    check("busy grant", {o_ch1_grant, o_ch0_grant}, 2'b01);
    seen = 1'b0;
    repeat (30) begin
      step();
      seen = seen | o_tx_start_en;
    end
    check("busy no_start", seen, 0);
    i_gmii_tx_busy = 1'b1;
    step();
    check("busy start", o_tx_start_en, 1);
    i_ch0_req = 1'b0;
    step();
    check("busy start_once", o_tx_start_en, 0);
    check("drop grant_held", o_ch0_grant, 1);
    complete_pkt(1'b0, "drop");
    repeat (IFG) step();

    // Watchdog expiry TMO cycles after the start pulse.
    i_ch0_req      = 1'b1;
    i_ch0_byte_num = 16'd256;
    step();
    check("tmo grant", {o_ch1_grant, o_ch0_grant}, 2'b01);
    step();
    check("tmo start", o_tx_start_en, 1);
    sb.push_back('{ch: 1'b0, err: 1'b1, to: 1'b1});
    n = 0;
    do begin
      step();
      n++;
    end while (!o_ch0_done && n < 3 * TMO);
    check("tmo latency", n, TMO);
    check("tmo grant_clr", o_ch0_grant, 0);
    i_ch0_req = 1'b0;
    step();
    check("tmo one_shot", {o_timeout_err, o_ch0_done, o_ch0_err}, 0);
    repeat (IFG - 1) step();

    // tx_done on the same cycle the watchdog expires: clean done, no error.
    i_ch0_req = 1'b1;
    step();
    step();
    check("tie start", o_tx_start_en, 1);
    repeat (TMO - 1) step();
    sb.push_back('{ch: 1'b0, err: 1'b0, to: 1'b0});
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("tie done", o_ch0_done, 1);
    check("tie no_timeout", o_timeout_err, 0);
    i_ch0_req = 1'b0;
    repeat (IFG) step();

    // Reset in WAIT_DONE: everything clears with no done pulse, and ch0 wins the next tie.
    i_ch0_req      = 1'b1;
    i_ch0_byte_num = 16'd800;
    step();
    step();
    check("rst_wd start", o_tx_start_en, 1);
    step();
    i_fifo_data_req = 1'b1;
    i_sys_rst       = 1'b1;
    step();
    check("rst_wd grants", {o_ch1_grant, o_ch0_grant}, 0);
    check("rst_wd pulses", {o_tx_start_en, o_ch0_done, o_ch1_done, o_ch0_err, o_ch1_err, o_timeout_err}, 0);
    check("rst_wd byte_num", o_tx_byte_num, 0);
    check("rst_wd des_mac", o_des_mac, 0);
    check("rst_wd des_ip", o_des_ip, 0);
    check("rst_wd tx_data", o_tx_data, 0);
    check("rst_wd data_req", {o_ch1_data_req, o_ch0_data_req}, 0);
    i_sys_rst       = 1'b0;
    i_fifo_data_req = 1'b0;
    i_ch1_req       = 1'b1;
    i_ch1_byte_num  = 16'd900;
    step();
    check("post_rst owner", {o_ch1_grant, o_ch0_grant}, 2'b01);
    step();
    check("post_rst start", o_tx_start_en, 1);
    step();
    complete_pkt(1'b0, "post_rst");
    i_ch0_req = 1'b0;
    i_ch1_req = 1'b0;
    repeat (IFG) step();

    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
